// File: rtl/media_min.sv
// -----------------------------------------------------------------------------
// media_min
// Downstream consumer of the three-channel minimum stage. Collects 2^LOG2N
// unsigned 8-bit samples over an active-low dav / rfd handshake, then offers
// their truncated (floor) mean over a second dav / rfd handshake. Upstream is
// stalled (rfd_in low) from the last sample of a block until the mean has been
// taken by the downstream consumer.
//
// Parameters:
//   LOG2N     log2 of samples per mean, legal range 1..4
// Ports:
//   clock     in   system clock, all state changes on posedge
//   reset_    in   asynchronous reset, active low
//   dav_in_   in   upstream data available, active low
//   x         in   upstream sample, valid while dav_in_ = 0
//   rfd_in    out  ready-for-data to upstream
//   media     out  mean of the last completed block of samples
//   dav_out_  out  data available to downstream, active low
//   rfd_out   in   downstream ready-for-data
// -----------------------------------------------------------------------------
module media_min #(
  parameter int LOG2N = 2
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav_in_,
  input  logic [7:0] x,
  output logic       rfd_in,
  output logic [7:0] media,
  output logic       dav_out_,
  input  logic       rfd_out
);

  // Accumulator is wide enough for 255 * 2^LOG2N, so it can never wrap.
  localparam int AW = 8 + LOG2N;

  localparam logic [1:0] S0 = 2'd0;  // wait for a sample
  localparam logic [1:0] S1 = 2'd1;  // wait for upstream to release dav_in_
  localparam logic [1:0] S2 = 2'd2;  // mean ready, wait for downstream ready
  localparam logic [1:0] S3 = 2'd3;  // mean offered, wait for downstream ack

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             rfd_in_q, rfd_in_d;
  logic             dav_out_q, dav_out_d;
  logic [7:0]       media_q, media_d;

  // Next-state and datapath decode for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rfd_in_d  = rfd_in_q;
    dav_out_d = dav_out_q;
    media_d   = media_q;
    case (state_q)
      S0: begin
        if (dav_in_ == 1'b0) begin
          // x is sampled only here, once per upstream handshake.
          acc_d    = acc_q + {{LOG2N{1'b0}}, x};
          cnt_d    = cnt_q + LOG2N'(1'b1);
          rfd_in_d = 1'b0;
          state_d  = S1;
        end else begin
          state_d = S0;
        end
      end
      S1: begin
        if (dav_in_ == 1'b1) begin
          // cnt wraps to zero exactly when the 2^LOG2N-th sample went in.
          if (cnt_q == '0) begin
            media_d = acc_q[AW-1:LOG2N];
            acc_d   = '0;
            state_d = S2;
          end else begin
            rfd_in_d = 1'b1;
            state_d  = S0;
          end
        end else begin
          state_d = S1;
        end
      end
      S2: begin
        // Upstream stays stalled; dav_in_ has no effect until back in S0.
        if (rfd_out == 1'b1) begin
          dav_out_d = 1'b0;
          state_d   = S3;
        end else begin
          state_d = S2;
        end
      end
      S3: begin
        if (rfd_out == 1'b0) begin
          dav_out_d = 1'b1;
          rfd_in_d  = 1'b1;
          state_d   = S0;
        end else begin
          state_d = S3;
        end
      end
      default: begin
        state_d   = S0;
        acc_d     = '0;
        cnt_d     = '0;
        rfd_in_d  = 1'b1;
        dav_out_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset discards any partial block or pending mean.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rfd_in_q  <= 1'b1;
      dav_out_q <= 1'b1;
      media_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rfd_in_q  <= rfd_in_d;
      dav_out_q <= dav_out_d;
      media_q   <= media_d;
    end
  end

  assign rfd_in   = rfd_in_q;
  assign dav_out_ = dav_out_q;
  assign media    = media_q;

endmodule

// File: tb/tb_media_min.sv
// -----------------------------------------------------------------------------
// tb_media_min
// Self-checking bench for media_min. Instance u0 runs with LOG2N=2, u1 with
// LOG2N=1. Expected means are computed by the bench from the driven samples,
// pushed to a queue per instance and popped when the DUT offers a result.
// Inputs change on the falling clock edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_media_min;

  logic       clock;
  logic       reset_;
  logic       dav_in_,  dav1_;
  logic [7:0] x,        x1;
  logic       rfd_in,   rfd1_in;
  logic [7:0] media,    media1;
  logic       dav_out_, dav1_out_;
  logic       rfd_out,  rfd1_out;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int         m_sum;
  int         m_cnt;
  int         m1_sum;
  int         m1_cnt;

  media_min #(.LOG2N(2)) u0 (
    .clock    (clock),
    .reset_   (reset_),
    .dav_in_  (dav_in_),
    .x        (x),
    .rfd_in   (rfd_in),
    .media    (media),
    .dav_out_ (dav_out_),
    .rfd_out  (rfd_out)
  );

  media_min #(.LOG2N(1)) u1 (
    .clock    (clock),
    .reset_   (reset_),
    .dav_in_  (dav1_),
    .x        (x1),
    .rfd_in   (rfd1_in),
    .media    (media1),
    .dav_out_ (dav1_out_),
    .rfd_out  (rfd1_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model for u0: floor mean of every 4 accepted samples.
  task automatic model_push(input logic [7:0] v);
    m_sum = m_sum + int'(v);
    m_cnt = m_cnt + 1;
    if (m_cnt == 4) begin
      exp_q.push_back(8'(m_sum / 4));
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // One full upstream handshake on u0 with dav_in_ low for one clock.
  task automatic send(input logic [7:0] v);
    int t;
    t = 0;
    while (rfd_in !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (rfd_in !== 1'b1) begin
      n_fail++;
      $display("FAIL send_wait_rfd_in: got %b, required 1", rfd_in);
    end
    dav_in_ = 1'b0;
    x       = v;
    model_push(v);
    @(negedge clock);
    dav_in_ = 1'b1;
    x       = 8'hA5;
    @(negedge clock);
  endtask

  // Wait for a result on u0, check it, then complete the downstream handshake.
  task automatic recv(input string nm);
    int         t;
    logic [7:0] e;
    t = 0;
    while (dav_out_ !== 1'b0 && t < 50) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_empty: no expected mean queued, media=%0d", nm, media);
    end else begin
      e = exp_q.pop_front();
      if (dav_out_ !== 1'b0 || media !== e) begin
        n_fail++;
        $display("FAIL %s_media: got dav_out_=%b media=%0d, required dav_out_=0 media=%0d",
                 nm, dav_out_, media, e);
      end
    end
    rfd_out = 1'b0;
    @(negedge clock);
    n_checks++;
    if (dav_out_ !== 1'b1 || rfd_in !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ack: got dav_out_=%b rfd_in=%b, required 1 1", nm, dav_out_, rfd_in);
    end
    rfd_out = 1'b1;
  endtask

  task automatic test_reset;
    reset_   = 1'b0;
    dav_in_  = 1'b1;
    dav1_    = 1'b1;
    x        = 8'd0;
    x1       = 8'd0;
    rfd_out  = 1'b1;
    rfd1_out = 1'b1;
    m_sum = 0; m_cnt = 0; m1_sum = 0; m1_cnt = 0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 || media !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_u0: got rfd_in=%b dav_out_=%b media=%0d, required 1 1 0",
               rfd_in, dav_out_, media);
    end
    n_checks++;
    if (rfd1_in !== 1'b1 || dav1_out_ !== 1'b1 || media1 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_u1: got rfd_in=%b dav_out_=%b media=%0d, required 1 1 0",
               rfd1_in, dav1_out_, media1);
    end
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic;
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    // One edge after the release the FSM is in S2: result not yet offered.
    n_checks++;
    if (dav_out_ !== 1'b1 || rfd_in !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_s2: got dav_out_=%b rfd_in=%b, required 1 0", dav_out_, rfd_in);
    end
    @(negedge clock);
    n_checks++;
    if (dav_out_ !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: got dav_out_=%b two edges after release, required 0", dav_out_);
    end
    recv("basic");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) send(8'd255);
    recv("sat_255");
    for (int i = 0; i < 4; i++) send(8'd0);
    recv("sat_0");
  endtask

  task automatic test_truncation;
    send(8'd1); send(8'd1); send(8'd1); send(8'd2);
    recv("trunc_5");
    send(8'd3); send(8'd3); send(8'd3); send(8'd2);
    recv("trunc_11");
  endtask

  task automatic test_back_pressure;
    logic [7:0] e;
    send(8'd50); send(8'd60); send(8'd70);
    rfd_out = 1'b0;
    send(8'd81);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        dav_in_ = 1'b0;
        x       = 8'd200;
      end else begin
        dav_in_ = 1'b1;
      end
      n_checks++;
      if (dav_out_ !== 1'b1 || rfd_in !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got dav_out_=%b rfd_in=%b, required 1 0", i, dav_out_, rfd_in);
      end
      @(negedge clock);
    end
    dav_in_ = 1'b1;
    rfd_out = 1'b1;
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++;
    if (dav_out_ !== 1'b0 || media !== e) begin
      n_fail++;
      $display("FAIL bp_release: got dav_out_=%b media=%0d, required 0 %0d", dav_out_, media, e);
    end
    rfd_out = 1'b0;
    @(negedge clock);
    rfd_out = 1'b1;
    // The stray 200 must not have been counted into this block.
    send(8'd8); send(8'd8); send(8'd8); send(8'd8);
    recv("bp_next");
  endtask

  task automatic test_reset_mid_block;
    send(8'd7); send(8'd7);
    reset_ = 1'b0;
    m_sum  = 0;
    m_cnt  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 || media !== 8'd0) begin
        n_fail++;
        $display("FAIL midrst[%0d]: got rfd_in=%b dav_out_=%b media=%0d, required 1 1 0",
                 i, rfd_in, dav_out_, media);
      end
    end
    reset_ = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) send(8'd100);
    recv("midrst_100");
  endtask

  task automatic test_single_pulse;
    logic [7:0] vals [2];
    logic [7:0] e;
    int         t;
    vals[0] = 8'd9;
    vals[1] = 8'd4;
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (rfd1_in !== 1'b1 && t < 50) begin
        @(negedge clock);
        t++;
      end
      dav1_  = 1'b0;
      x1     = vals[i];
      m1_sum = m1_sum + int'(vals[i]);
      m1_cnt = m1_cnt + 1;
      if (m1_cnt == 2) begin
        exp1_q.push_back(8'(m1_sum / 2));
        m1_sum = 0;
        m1_cnt = 0;
      end
      @(negedge clock);
      dav1_ = 1'b1;
      x1    = 8'h3C;
      @(negedge clock);
    end
    t = 0;
    while (dav1_out_ !== 1'b0 && t < 50) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (exp1_q.size() == 0) begin
      n_fail++;
      $display("FAIL pulse_empty: no expected mean queued, media=%0d", media1);
    end else begin
      e = exp1_q.pop_front();
      if (dav1_out_ !== 1'b0 || media1 !== e) begin
        n_fail++;
        $display("FAIL pulse_media: got dav_out_=%b media=%0d, required 0 %0d",
                 dav1_out_, media1, e);
      end
    end
    rfd1_out = 1'b0;
    @(negedge clock);
    n_checks++;
    if (dav1_out_ !== 1'b1 || rfd1_in !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_ack: got dav_out_=%b rfd_in=%b, required 1 1", dav1_out_, rfd1_in);
    end
    rfd1_out = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_truncation();
    test_back_pressure();
    test_reset_mid_block();
    test_single_pulse();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected means never produced, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
